countdown_2n: RTL and testbench

COUNTDOWN_2N -- requirements
Module: countdown_2n

---
 rtl/counter_pkg.sv | 12 +
 rtl/downcounter_n.sv | 36 +++
 rtl/countdown_2n.sv | 108 ++++++++++
 tb/tb_countdown_2n.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the split-half countdown timer.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/downcounter_n.sv
// Loadable wrapping down-counter; borrow_out flags a decrement from zero.
module downcounter_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] cnt,
    output logic             borrow_out
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (enable) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign borrow_out = enable && (cnt_q == '0);

endmodule

// File: rtl/countdown_2n.sv
// Countdown timer built from two half-width down-counters, with one-shot or
// periodic auto-reload and a registered terminal-count pulse.
module countdown_2n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload_mode,
    output logic [WIDTH-1:0] cnt,
    output logic             expired,
    output logic             busy,
    output logic             zero
);

    localparam int unsigned HALF = WIDTH / 2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reload_q;
    logic             expired_q;

    logic [HALF-1:0]  lo_cnt, hi_cnt;
    logic             lo_borrow;
    logic             hi_borrow;
    logic             is_one;
    logic             terminal;
    logic             decrement;
    logic             half_load;
    logic [WIDTH-1:0] half_value;

    assign cnt    = {hi_cnt, lo_cnt};
    assign is_one = (cnt == WIDTH'(1));

    // Terminal count reloads (or clears) the halves instead of decrementing,
    // so the high half never sees a borrow out of 1.
    assign terminal   = (state_q == RUN) && enable && !load && is_one;
    assign decrement  = (state_q == RUN) && enable && !load && !is_one;
    assign half_load  = load || terminal;
    assign half_value = load ? load_value : (reload_mode ? reload_q : '0);

    downcounter_n #(
        .WIDTH (HALF)
    ) u_lo (
        .clk        (clk),
        .reset      (reset),
        .enable     (decrement),
        .load       (half_load),
        .load_value (half_value[HALF-1:0]),
        .cnt        (lo_cnt),
        .borrow_out (lo_borrow)
    );

    downcounter_n #(
        .WIDTH (HALF)
    ) u_hi (
        .clk        (clk),
        .reset      (reset),
        .enable     (lo_borrow),
        .load       (half_load),
        .load_value (half_value[WIDTH-1:HALF]),
        .cnt        (hi_cnt),
        .borrow_out (hi_borrow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_value != '0) ? RUN : IDLE;
        end else if (terminal && !reload_mode) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            if (load) begin
                reload_q <= load_value;
            end
            expired_q <= terminal;
        end
    end

    always_comb begin
        busy    = (state_q == RUN);
        zero    = (cnt == '0);
        expired = expired_q;
    end

    // The high half's borrow can only fire on underflow, which RUN never reaches.
    logic unused_hi_borrow;
    assign unused_hi_borrow = hi_borrow;

endmodule

// File: tb/tb_countdown_2n.sv
// Self-checking bench for countdown_2n: directed scenarios plus randomized
// traffic compared against a whole-count behavioural model.
module tb_countdown_2n;

    logic       clk = 1'b0;
    logic       reset, enable, load, reload_mode;
    logic [7:0] load_value;
    logic [7:0] cnt;
    logic       expired, busy, zero;

    logic        w_reset, w_enable, w_load, w_reload_mode;
    logic [63:0] w_load_value, w_cnt;
    logic        w_expired, w_busy, w_zero;

    int checks   = 0;
    int failures = 0;

    // Model: 0 = idle, 1 = run, 2 = done.
    int         m_st;
    logic [7:0] m_cnt, m_reload;
    logic       m_exp;

    always #5 clk = ~clk;

    countdown_2n #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .reload_mode (reload_mode),
        .cnt         (cnt),
        .expired     (expired),
        .busy        (busy),
        .zero        (zero)
    );

    countdown_2n #(.WIDTH(64)) dut_w (
        .clk         (clk),
        .reset       (w_reset),
        .enable      (w_enable),
        .load        (w_load),
        .load_value  (w_load_value),
        .reload_mode (w_reload_mode),
        .cnt         (w_cnt),
        .expired     (w_expired),
        .busy        (w_busy),
        .zero        (w_zero)
    );

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic step(input logic r, input logic ld, input logic [7:0] lv,
                        input logic rm, input logic en);
        reset       = r;
        load        = ld;
        load_value  = lv;
        reload_mode = rm;
        enable      = en;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_reload = 0; m_exp = 0; m_st = 0;
        end else if (ld) begin
            m_cnt = lv; m_reload = lv; m_exp = 0; m_st = (lv != 0) ? 1 : 0;
        end else if (m_st == 1 && en) begin
            if (m_cnt == 1) begin
                m_exp = 1;
                if (rm) m_cnt = m_reload;
                else begin m_cnt = 0; m_st = 2; end
            end else begin
                m_cnt = m_cnt - 1;
                m_exp = 0;
            end
        end else begin
            m_exp = 0;
        end
        #1;
    endtask

    task automatic w_step(input logic r, input logic ld, input logic [63:0] lv, input logic en);
        w_reset       = r;
        w_load        = ld;
        w_load_value  = lv;
        w_reload_mode = 1'b0;
        w_enable      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        w_step(1, 0, 64'd0, 0);
        checks++;
        if (cnt !== 8'd0 || expired !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: cnt=%0h exp=%b busy=%b zero=%b, want 0 0 0 1",
                     cnt, expired, busy, zero);
        end
        checks++;
        if (w_cnt !== 64'd0 || w_busy !== 1'b0 || w_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_state_wide: cnt=%0h busy=%b zero=%b, want 0 0 1",
                     w_cnt, w_busy, w_zero);
        end
        // Reset must beat a simultaneous load.
        step(1, 1, 8'h07, 0, 1);
        checks++;
        if (cnt !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_load: cnt=%0h busy=%b, want 0 0", cnt, busy);
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] want_cnt [3] = '{8'd2, 8'd1, 8'd0};
        logic       want_exp [3] = '{1'b0, 1'b0, 1'b1};
        int         pulses = 0;
        step(0, 1, 8'h03, 0, 1);
        checks++;
        if (cnt !== 8'd3 || busy !== 1'b1 || expired !== 1'b0) begin
            failures++;
            $display("FAIL one_shot_load: cnt=%0h busy=%b exp=%b, want 3 1 0", cnt, busy, expired);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            if (expired) pulses++;
            checks++;
            if (cnt !== want_cnt[i] || expired !== want_exp[i]) begin
                failures++;
                $display("FAIL one_shot_seq%0d: cnt=%0h exp=%b, want %0h %b",
                         i, cnt, expired, want_cnt[i], want_exp[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            if (expired) pulses++;
        end
        checks++;
        if (cnt !== 8'd0 || busy !== 1'b0 || zero !== 1'b1 || pulses != 1) begin
            failures++;
            $display("FAIL one_shot_done: cnt=%0h busy=%b zero=%b pulses=%0d, want 0 0 1 1",
                     cnt, busy, zero, pulses);
        end
    endtask

    task automatic test_borrow();
        step(0, 1, 8'h10, 0, 0);
        step(0, 0, 0, 0, 1);
        checks++;
        if (cnt !== 8'h0F) begin
            failures++;
            $display("FAIL borrow: cnt=%0h, want 0f", cnt);
        end
        step(0, 1, 8'h00, 0, 1);
        checks++;
        if (cnt !== 8'h00 || busy !== 1'b0 || zero !== 1'b1 || expired !== 1'b0) begin
            failures++;
            $display("FAIL load_zero: cnt=%0h busy=%b zero=%b exp=%b, want 0 0 1 0",
                     cnt, busy, zero, expired);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (cnt !== 8'h00 || expired !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: cnt=%0h exp=%b, want 0 0", cnt, expired);
        end
    endtask

    task automatic test_reload();
        int         pulses = 0;
        logic [7:0] want;
        step(0, 1, 8'h04, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 1, 1);
            if (expired) pulses++;
            want = (k % 4 == 0) ? 8'd4 : 8'(4 - (k % 4));
            checks++;
            if (cnt !== want || expired !== (k % 4 == 0) || busy !== 1'b1) begin
                failures++;
                $display("FAIL reload_k%0d: cnt=%0h exp=%b busy=%b, want %0h %b 1",
                         k, cnt, expired, busy, want, (k % 4 == 0));
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL reload_pulses: got %0d, want 3", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int en_count = 0;
        int bad = 0;
        step(0, 1, 8'h05, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        checks++;
        if (cnt !== 8'd1) begin
            failures++;
            $display("FAIL sim_setup: cnt=%0h, want 1", cnt);
        end
        step(0, 1, 8'h05, 1, 1);
        checks++;
        if (cnt !== 8'd5 || expired !== 1'b0) begin
            failures++;
            $display("FAIL load_beats_enable: cnt=%0h exp=%b, want 5 0", cnt, expired);
        end
        step(0, 1, 8'h04, 1, 0);
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 1, (i % 2 == 0));
            if (i % 2 == 0) en_count++;
            if (expired !== (en_count % 4 == 0 && i % 2 == 0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL toggled_period: %0d cycles with wrong expired, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_run();
        step(0, 1, 8'h05, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (cnt !== 8'd2) begin
            failures++;
            $display("FAIL mid_run_setup: cnt=%0h, want 2", cnt);
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (cnt !== 8'd0 || busy !== 1'b0 || expired !== 1'b0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_run: cnt=%0h busy=%b exp=%b zero=%b, want 0 0 0 1",
                     cnt, busy, expired, zero);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (expired !== 1'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_quiet: cnt=%0h exp=%b, want 0 0", cnt, expired);
        end
    endtask

    task automatic test_wide();
        w_step(0, 1, 64'h0000_0001_0000_0000, 0);
        w_step(0, 0, 64'd0, 1);
        checks++;
        if (w_cnt !== 64'h0000_0000_FFFF_FFFF || w_busy !== 1'b1) begin
            failures++;
            $display("FAIL wide_borrow: cnt=%0h busy=%b, want ffffffff 1", w_cnt, w_busy);
        end
        w_step(0, 0, 64'd0, 0);
        checks++;
        if (w_cnt !== 64'h0000_0000_FFFF_FFFF) begin
            failures++;
            $display("FAIL wide_hold: cnt=%0h, want ffffffff", w_cnt);
        end
    endtask

    task automatic test_random();
        logic       r, ld, rm, en;
        logic [7:0] lv;
        int         bad = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 9) == 0);
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            rm = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            step(r, ld, lv, rm, en);
            if (cnt !== m_cnt || expired !== m_exp || busy !== (m_st == 1) ||
                zero !== (m_cnt == 0)) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d: cnt=%0h exp=%b busy=%b zero=%b, want %0h %b %b %b",
                             i, cnt, expired, busy, zero, m_cnt, m_exp, (m_st == 1), (m_cnt == 0));
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_total: %0d mismatching cycles, want 0", bad);
        end
    endtask

    initial begin
        reset = 1; enable = 0; load = 0; load_value = 0; reload_mode = 0;
        w_reset = 1; w_enable = 0; w_load = 0; w_load_value = 0; w_reload_mode = 0;
        m_st = 0; m_cnt = 0; m_reload = 0; m_exp = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_one_shot();
        test_borrow();
        test_reload();
        test_simultaneous();
        test_reset_mid_run();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
